baud_gen: RTL
=============

# baud_gen

Parametrised fractional baud-rate tick generator for the UART datapath. It replaces the fixed terminal-count divider with an integer-plus-fractional prescaler. An oversampling counter produces sample, mid-bit and bit ticks. Divisor updates are shadowed, and a synchronous restart lets the receiver realign on a start bit. It sits between the system clock domain and the UART TX/RX state machines, which consume its ticks as clock enables.

## Interface
Parameters:
- DIV_W, 16, width of the integer divisor and prescaler counter
- FRAC_W, 4, width of the fractional divisor and phase accumulator
- OSR, 16, samples per bit; power of two, minimum 4; SIDX_W = log2(OSR)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  reset, asynchronous, active-low
- enable  input  1  count enable; when low, all counters freeze
- restart  input  1  synchronous realign pulse; priority over enable
- div_int  input  DIV_W  integer sample period in clk cycles
- div_frac  input  FRAC_W  fractional period, in units of 1/2^FRAC_W cycle
- div_load  input  1  one-cycle pulse that captures div_int/div_frac into the shadow registers
- div_pending  output  1  shadow divisor captured but not yet active
- sample_tick  output  1  one-cycle pulse at each sample period end
- mid_tick  output  1  pulse with sample_tick when sidx == OSR/2-1
- bit_tick  output  1  pulse with sample_tick when sidx == OSR-1
- sidx  output  SIDX_W  current sample index within the bit

## Operation
- Registers:
  - cnt (DIV_W), the prescaler.
  - sidx, the sample index.
  - acc (FRAC_W), the phase accumulator.
  - act_int/act_frac, the active divisor.
  - sh_int/sh_frac, the shadow divisor.
  - pend, the pending flag.
  - carry, which extends the current period.
- Effective base period P = max(act_int, 1). A value of 0 is treated as 1, giving a tick every enabled cycle.
- Current period length L = P + carry. carry is set at each period end from the overflow of acc + act_frac, computed at FRAC_W+1 bits. acc takes the low FRAC_W bits.
- Period end: occurs on an enabled cycle with cnt == L-1. On that edge:
  - cnt←0.
  - sidx←sidx+1, wrapping modulo OSR.
  - acc and carry are updated.
  - sample_tick←1. mid_tick and bit_tick are decoded from the pre-increment sidx.
- Otherwise, on an enabled cycle: cnt←cnt+1 and all ticks←0.
- enable low: cnt, sidx and acc hold; all ticks←0.
- Divisor update:
  - div_load copies the inputs into the shadow registers and sets pend.
  - At the next period end (or restart), act←sh and pend clears. The new divisor governs the period beginning at that edge.
  - div_load while pend=1 overwrites the shadow.
  - div_load coincident with a period end applies the newly presented values directly; pend stays 0.
  - If enable is low and pend=1, the shadow is applied on the next cycle.
- restart:
  - cnt←0, sidx←0, acc←0, carry←0, all ticks←0.
  - A pending shadow is applied.
  - Takes effect regardless of enable.

## Timing
- All outputs are registered. Reset values: sample_tick=0, mid_tick=0, bit_tick=0, sidx=0, div_pending=0.
- Reset values of internal state: cnt=0, acc=0, carry=0, act_int=sh_int=OSR, act_frac=sh_frac=0.
- With enable held high from reset release, the first sample_tick is high in the cycle after the P-th rising edge. Subsequent ticks are spaced exactly L cycles apart.
- Tick spacing is also exactly L cycles after restart.
- bit_tick spacing: the sum of OSR consecutive L values. The average is OSR·(act_int + act_frac/2^FRAC_W).
- div_pending rises the cycle after div_load and falls the cycle after the applying edge.
- Ticks are never wider than one cycle, including when P=1.
- Asserting reset mid-period immediately clears all state and outputs. Any pending load is lost.

## Configuration
- BAUD_GEN_FRAC_EN defined: fractional accumulator and carry logic are built, and behaviour is as above.
- BAUD_GEN_FRAC_EN undefined:
  - acc, carry and sh_frac/act_frac are not built.
  - div_frac remains a port but is ignored.
  - L = P always, and all ticks are exactly periodic.

## Test plan
- Reset release, enable=1, default divisor (act_int=16, frac=0) → sample_tick every 16 cycles; bit_tick every 256 cycles; mid_tick 128 cycles before each bit_tick; sidx cycles 0..15.
- div_int=10, div_frac=8 (FRAC_W=4, macro defined) → sample periods alternate 10,11 → 16 samples take exactly 168 cycles; with macro undefined, 160 cycles.
- Mid-period div_load with div_int=5 → div_pending=1 until the next sample_tick, then 5-cycle periods; a second load while pending → only the second value is applied.
- restart pulse while enable=0 at sidx=7 → next cycle sidx=0 and cnt=0; after enable=1, first sample_tick after exactly P cycles.
- div_int=0 and div_int=1 → sample_tick high every enabled cycle, bit_tick every OSR cycles; enable toggled 1/0 → counts freeze and no ticks while low.
- reset_n asserted mid-bit with a load pending → all outputs 0 immediately; after release, div_pending=0 and period=16.

Source files
------------

// File: rtl/baud_gen.sv
// Fractional baud-rate tick generator for the UART datapath.
// An integer-plus-fractional prescaler produces sample ticks; an oversampling
// index decodes mid-bit and bit ticks from them. Divisor updates go through a
// shadow register and take effect at a period boundary, on restart, or on the
// next cycle while counting is disabled.
// Build option: define BAUD_GEN_FRAC_EN to build the fractional phase
// accumulator. Without it div_frac is ignored and every period is exactly
// max(div_int, 1) cycles.
module baud_gen #(
    parameter  int DIV_W  = 16,
    parameter  int FRAC_W = 4,
    parameter  int OSR    = 16,
    localparam int SIDX_W = $clog2(OSR)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              restart,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              div_pending,
    output logic              sample_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic [SIDX_W-1:0] sidx
);

    logic [DIV_W-1:0]  r_cnt;
    logic [SIDX_W-1:0] r_sidx;
    logic [DIV_W-1:0]  r_act_int;
    logic [DIV_W-1:0]  r_sh_int;
    logic              r_pend;
    logic              r_sample;
    logic              r_mid;
    logic              r_bit;

    logic [DIV_W-1:0]  w_p_m1;
    logic [DIV_W-1:0]  w_last;
    logic              w_end;
    logic              w_apply;

`ifdef BAUD_GEN_FRAC_EN
    logic [FRAC_W-1:0] r_acc;
    logic              r_carry;
    logic [FRAC_W-1:0] r_act_frac;
    logic [FRAC_W-1:0] r_sh_frac;
    logic [FRAC_W:0]   w_acc_sum;

    assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_act_frac};
    // A carry stretches the current period by one cycle.
    assign w_last    = w_p_m1 + {{(DIV_W-1){1'b0}}, r_carry};
`else
    logic w_unused_frac;

    assign w_unused_frac = ^div_frac;
    assign w_last        = w_p_m1;
`endif

    // A divisor of zero behaves like one: a tick on every enabled cycle.
    assign w_p_m1  = (r_act_int == '0) ? '0 : r_act_int - DIV_W'(1);
    assign w_end   = enable && !restart && (r_cnt == w_last);
    // Points at which the shadow divisor may become active.
    assign w_apply = restart || w_end || (!enable && r_pend);

    // Prescaler, sample index and registered tick outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_sidx   <= '0;
            r_sample <= 1'b0;
            r_mid    <= 1'b0;
            r_bit    <= 1'b0;
        end else if (restart) begin
            r_cnt    <= '0;
            r_sidx   <= '0;
            r_sample <= 1'b0;
            r_mid    <= 1'b0;
            r_bit    <= 1'b0;
        end else if (enable) begin
            if (w_end) begin
                r_cnt    <= '0;
                r_sidx   <= r_sidx + SIDX_W'(1);
                r_sample <= 1'b1;
                r_mid    <= (r_sidx == SIDX_W'(OSR/2 - 1));
                r_bit    <= (r_sidx == SIDX_W'(OSR - 1));
            end else begin
                r_cnt    <= r_cnt + DIV_W'(1);
                r_sample <= 1'b0;
                r_mid    <= 1'b0;
                r_bit    <= 1'b0;
            end
        end else begin
            r_sample <= 1'b0;
            r_mid    <= 1'b0;
            r_bit    <= 1'b0;
        end
    end

`ifdef BAUD_GEN_FRAC_EN
    // Phase accumulator: overflow at a period end lengthens the next period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else if (restart) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else if (w_end) begin
            r_acc   <= w_acc_sum[FRAC_W-1:0];
            r_carry <= w_acc_sum[FRAC_W];
        end
    end
`endif

    // Shadow/active divisor: a load arriving on an apply edge bypasses the shadow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_act_int  <= DIV_W'(OSR);
            r_sh_int   <= DIV_W'(OSR);
            r_pend     <= 1'b0;
`ifdef BAUD_GEN_FRAC_EN
            r_act_frac <= '0;
            r_sh_frac  <= '0;
`endif
        end else if (w_apply) begin
            r_pend <= 1'b0;
            if (div_load) begin
                r_act_int  <= div_int;
                r_sh_int   <= div_int;
`ifdef BAUD_GEN_FRAC_EN
                r_act_frac <= div_frac;
                r_sh_frac  <= div_frac;
`endif
            end else begin
                r_act_int  <= r_sh_int;
`ifdef BAUD_GEN_FRAC_EN
                r_act_frac <= r_sh_frac;
`endif
            end
        end else if (div_load) begin
            r_sh_int  <= div_int;
`ifdef BAUD_GEN_FRAC_EN
            r_sh_frac <= div_frac;
`endif
            r_pend    <= 1'b1;
        end
    end

    assign div_pending = r_pend;
    assign sample_tick = r_sample;
    assign mid_tick    = r_mid;
    assign bit_tick    = r_bit;
    assign sidx        = r_sidx;

endmodule
